// File: rtl/bram_if.sv
// bram_if: read/write/clear port bundle for bram_init_be.
interface bram_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int NUM_LANES  = 4
);
   logic                  clear_req;
   logic                  init_done;
   logic                  read_enable;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  read_valid;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [NUM_LANES-1:0]  write_byte_en;
   modport master (
      output clear_req, read_enable, read_addr, write_enable, write_addr, write_data, write_byte_en,
      input  init_done, read_data, read_valid
   );
   modport slave (
      input  clear_req, read_enable, read_addr, write_enable, write_addr, write_data, write_byte_en,
      output init_done, read_data, read_valid
   );
endinterface

// File: rtl/bram_init_be.sv
// bram_init_be: simple dual-port RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write result and a hardware clear sweep.
module bram_init_be #(
   parameter int DATA_WIDTH   = 32,
   parameter int BYTE_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 9,
   parameter int NUM_ROWS     = 512,
   parameter int READ_LATENCY = 1,
   parameter int RW_MODE      = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input logic clk,
   input logic rst,
   bram_if.slave bus
);
   localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
   typedef enum logic {CLEAR, READY} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
   logic [DATA_WIDTH-1:0] mem [NUM_ROWS];
   logic [DATA_WIDTH-1:0] rd_row, d1, d2;
   logic v1, v2, rd_acc, wr_acc, last;

   assign last   = ptr == ADDR_WIDTH'(NUM_ROWS - 1);
   assign rd_acc = bus.read_enable && state == READY;
   assign wr_acc = bus.write_enable && state == READY && !rst &&
                   ({1'b0, bus.write_addr} < (ADDR_WIDTH + 1)'(NUM_ROWS));
   assign bus.init_done  = state == READY;
   assign bus.read_valid = READ_LATENCY == 2 ? v2 : v1;
   assign bus.read_data  = READ_LATENCY == 2 ? d2 : d1;

   always_comb begin
      state_nxt = state == CLEAR ? (last ? READY : CLEAR) : (bus.clear_req ? CLEAR : READY);
      ptr_nxt   = state == CLEAR && !last ? ptr + 1'b1 : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Storage has no reset; the sweep provides the known contents.
   always_ff @(posedge clk) begin
      if (state == CLEAR && !rst)
         mem[ptr] <= INIT_VALUE;
      else if (wr_acc)
         for (int i = 0; i < NUM_LANES; i++)
            if (bus.write_byte_en[i])
               mem[bus.write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
   end

   always_comb begin
      rd_row = mem[bus.read_addr];
      if (RW_MODE == 1 && wr_acc && bus.write_addr == bus.read_addr)
         for (int i = 0; i < NUM_LANES; i++)
            if (bus.write_byte_en[i])
               rd_row[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
   end

   // Data registers only load on a valid beat so the output holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         d1 <= '0;
         d2 <= '0;
      end else begin
         v1 <= rd_acc;
         v2 <= v1;
         if (rd_acc) d1 <= rd_row;
         if (v1) d2 <= d1;
      end
   end
endmodule

// File: tb/tb_bram_init_be.sv
// tb_bram_init_be: directed checks of two instances (latency 1/old-data, latency 2/new-data)
// driven with identical stimulus.
module tb_bram_init_be;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_tests = 0;
   int n_fail = 0;
   int cnt, vcnt;

   always #5 clk = ~clk;

   bram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_LANES(4)) a_if ();
   bram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_LANES(4)) b_if ();

   assign b_if.clear_req     = a_if.clear_req;
   assign b_if.read_enable   = a_if.read_enable;
   assign b_if.read_addr     = a_if.read_addr;
   assign b_if.write_enable  = a_if.write_enable;
   assign b_if.write_addr    = a_if.write_addr;
   assign b_if.write_data    = a_if.write_data;
   assign b_if.write_byte_en = a_if.write_byte_en;

   bram_init_be #(.READ_LATENCY(1), .RW_MODE(0)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
   bram_init_be #(.READ_LATENCY(2), .RW_MODE(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      a_if.clear_req     = 1'b0;
      a_if.read_enable   = 1'b0;
      a_if.read_addr     = '0;
      a_if.write_enable  = 1'b0;
      a_if.write_addr    = '0;
      a_if.write_data    = '0;
      a_if.write_byte_en = '0;
   endtask

   task automatic wr(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
      a_if.write_enable  = 1'b1;
      a_if.write_addr    = addr;
      a_if.write_data    = data;
      a_if.write_byte_en = be;
      @(negedge clk);
      idle();
   endtask

   // Read raddr, optionally with a write in the same cycle; ea/eb are the expected results.
   task automatic xfer(input logic [8:0] raddr, input logic we, input logic [8:0] waddr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] ea, input logic [31:0] eb);
      a_if.read_enable   = 1'b1;
      a_if.read_addr     = raddr;
      a_if.write_enable  = we;
      a_if.write_addr    = waddr;
      a_if.write_data    = wdata;
      a_if.write_byte_en = be;
      @(negedge clk);
      idle();
      check("a_valid_l1", 32'(a_if.read_valid), 1);
      check("a_data", a_if.read_data, ea);
      check("b_valid_early", 32'(b_if.read_valid), 0);
      @(negedge clk);
      check("b_valid_l2", 32'(b_if.read_valid), 1);
      check("b_data", b_if.read_data, eb);
      check("a_valid_pulse", 32'(a_if.read_valid), 0);
   endtask

   task automatic rd(input logic [8:0] addr, input logic [31:0] exp);
      xfer(addr, 1'b0, '0, '0, '0, exp, exp);
   endtask

   task automatic wait_init();
      cnt = 0;
      while (!a_if.init_done && cnt < 1000) begin
         @(negedge clk);
         cnt++;
         vcnt += int'(a_if.read_valid) + int'(b_if.read_valid);
      end
   endtask

   initial begin
      idle();
      vcnt = 0;
      @(negedge clk);
      check("rst_init_done", 32'({a_if.init_done, b_if.init_done}), 0);
      check("rst_valid", 32'({a_if.read_valid, b_if.read_valid}), 0);
      check("rst_data_a", a_if.read_data, 0);
      check("rst_data_b", b_if.read_data, 0);
      rst = 1'b0;
      wait_init();
      check("init_cycles", cnt, 512);
      check("init_done_b", 32'(b_if.init_done), 1);
      check("init_sweep_valid", vcnt, 0);
      rd(0, 0);
      rd(255, 0);
      rd(511, 0);

      wr(7, 32'hDEADBEEF, 4'b1111);
      wr(7, 32'h00001234, 4'b0011);
      rd(7, 32'hDEAD1234);
      wr(7, 32'hFFFFFFFF, 4'b0000);
      rd(7, 32'hDEAD1234);

      wr(3, 32'h11111111, 4'b1111);
      xfer(3, 1'b1, 3, 32'h22222222, 4'b1000, 32'h11111111, 32'h22111111);
      rd(3, 32'h22111111);
      xfer(7, 1'b1, 8, 32'hABCD5678, 4'b1111, 32'hDEAD1234, 32'hDEAD1234);
      rd(8, 32'hABCD5678);

      for (int i = 0; i < 16; i++) wr(9'(i), 32'hC0DE0000 + i, 4'b1111);
      for (int k = 0; k < 18; k++) begin
         check("b2b_a_valid", 32'(a_if.read_valid), (k >= 1 && k <= 16) ? 1 : 0);
         if (k >= 1 && k <= 16) check("b2b_a_data", a_if.read_data, 32'hC0DE0000 + k - 1);
         check("b2b_b_valid", 32'(b_if.read_valid), (k >= 2) ? 1 : 0);
         if (k >= 2) check("b2b_b_data", b_if.read_data, 32'hC0DE0000 + k - 2);
         a_if.read_enable = k < 16;
         a_if.read_addr   = 9'(k);
         @(negedge clk);
      end
      idle();

      a_if.clear_req = 1'b1;
      wr(20, 32'h55555555, 4'b1111);
      check("clr_init_low", 32'(a_if.init_done), 0);
      cnt = 0;
      vcnt = 0;
      while (!a_if.init_done && cnt < 1000) begin
         if (cnt == 30) begin
            a_if.read_enable   = 1'b1;
            a_if.read_addr     = 7;
            a_if.write_enable  = 1'b1;
            a_if.write_addr    = 2;
            a_if.write_data    = 32'hFFFFFFFF;
            a_if.write_byte_en = 4'b1111;
         end else idle();
         @(negedge clk);
         cnt++;
         vcnt += int'(a_if.read_valid) + int'(b_if.read_valid);
      end
      idle();
      check("clr_cycles", cnt, 512);
      check("clr_sweep_valid", vcnt, 0);
      rd(2, 0);
      rd(7, 0);
      rd(20, 0);
      rd(511, 0);

      wr(7, 32'h0BADF00D, 4'b1111);
      a_if.read_enable = 1'b1;
      a_if.read_addr   = 7;
      @(negedge clk);
      idle();
      check("inflight_a_done", a_if.read_data, 32'h0BADF00D);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("inflight_b_dropped", 32'(b_if.read_valid), 0);
      check("inflight_init_low", 32'(a_if.init_done), 0);
      vcnt = 0;
      repeat (200) begin
         @(negedge clk);
         vcnt += int'(a_if.read_valid) + int'(b_if.read_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_init();
      check("rerst_cycles", cnt, 512);
      check("rerst_valid", vcnt, 0);
      rd(7, 0);
      rd(0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
